// File: rtl/usb_pkt_encoder_pkg.sv
// Shared types and constants for the USB packet encoder: FSM states,
// PID-type codes, packet field layout, CRC parameters and stuffing limit.
package usb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_BODY,
        ST_CRC,
        ST_EOP1,
        ST_EOP2,
        ST_BAD
    } state_t;

    // PID type, taken from the two leading PID bits on the wire
    localparam logic [1:0] PID_TOKEN = 2'b10;
    localparam logic [1:0] PID_DATA  = 2'b11;
    localparam logic [1:0] PID_HS    = 2'b01;

    // Packet layout inside the 99-bit input word (bit 98 goes out first)
    localparam int PKT_W    = 99;
    localparam int HS_MSB   = 95;
    localparam int HS_LSB   = 80;
    localparam int HDR_MSB  = 98;
    localparam int HDR_LSB  = 83;
    localparam int TOK_MSB  = 82;
    localparam int TOK_LSB  = 72;
    localparam int DAT_MSB  = 82;
    localparam int DAT_LSB  = 19;
    localparam int TYPE_MSB = 90;
    localparam int TYPE_LSB = 89;

    // Phase lengths in bits
    localparam logic [6:0] HDR_LEN   = 7'd16;
    localparam logic [6:0] TOK_LEN   = 7'd11;
    localparam logic [6:0] DAT_LEN   = 7'd64;
    localparam logic [6:0] CRC5_LEN  = 7'd5;
    localparam logic [6:0] CRC16_LEN = 7'd16;

    // Header + longest body, shifted out MSB first
    localparam int SHREG_W = 80;

    localparam logic [4:0]  CRC5_POLY  = 5'h05;
    localparam logic [4:0]  CRC5_INIT  = 5'h1F;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    localparam logic [2:0] STUFF_LIMIT = 3'd6;

    // Number of wire bits in the given transmit phase
    function automatic logic [6:0] phase_len(input state_t st, input logic is_data);
        case (st)
            ST_HDR:  phase_len = HDR_LEN;
            ST_BODY: phase_len = is_data ? DAT_LEN : TOK_LEN;
            ST_CRC:  phase_len = is_data ? CRC16_LEN : CRC5_LEN;
            default: phase_len = 7'd0;
        endcase
    endfunction

endpackage

// File: rtl/usb_pkt_encoder_if.sv
// Packet handshake from the protocol FSM plus the serial stream towards
// the NRZI stage. The encoder is the slave side.
interface usb_pkt_encoder_if;
    import usb_pkg::*;

    logic [PKT_W-1:0] pktIn;
    logic             pktInAvail;
    logic             readyEC;
    logic             sOut;
    logic             sValid;
    logic             sEop;
    logic             badPkt;

    modport master (
        output pktIn, pktInAvail,
        input  readyEC, sOut, sValid, sEop, badPkt
    );

    modport slave (
        input  pktIn, pktInAvail,
        output readyEC, sOut, sValid, sEop, badPkt
    );
endinterface

// File: rtl/usb_pkt_encoder_crc.sv
// Bit-serial CRC, one message bit per enabled cycle, register MSB is the
// feedback tap. init reloads the seed for the next packet.
module crc_serial #(
    parameter int               WIDTH = 5,
    parameter logic [WIDTH-1:0] POLY  = '0,
    parameter logic [WIDTH-1:0] INIT  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] crc
);
    logic [WIDTH-1:0] crc_reg;
    logic             fb;

    assign fb  = crc_reg[WIDTH-1] ^ din;
    assign crc = crc_reg;

    // Seed on reset/init, otherwise shift one message bit when enabled
    always_ff @(posedge clk) begin
        if (rst || init) begin
            crc_reg <= INIT;
        end else if (en) begin
            crc_reg <= {crc_reg[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end
endmodule

// File: rtl/usb_pkt_encoder.sv
// Serializes one packet per handshake: header, body, complemented CRC,
// zero-stuffing after six ones, then a two-cycle SE0 end-of-packet.
module usb_pkt_encoder
    import usb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    usb_pkt_encoder_if.slave  bus
);
    state_t               state_reg, state_next;
    logic [SHREG_W-1:0]   shreg_reg;
    logic [6:0]           bit_cnt_reg;
    logic [2:0]           ones_cnt_reg;
    logic                 is_hs_reg, is_data_reg;

    logic                 accept, in_is_hs, in_good;
    logic [1:0]           in_type;
    logic                 active, stuff, data_bit, tx_bit;
    logic                 last_bit, in_tail;
    logic [2:0]           ones_after;
    logic [6:0]           cur_len;
    logic [4:0]           crc5;
    logic [15:0]          crc16, crc_tx;
    logic                 unused_pkt_bits;

    assign unused_pkt_bits = ^bus.pktIn[DAT_LSB-1:0];

    assign accept   = (state_reg == ST_IDLE) && bus.pktInAvail;
    assign in_type  = bus.pktIn[TYPE_MSB:TYPE_LSB];
    assign in_is_hs = (bus.pktIn[PKT_W-1:PKT_W-3] == 3'b000);
    assign in_good  = in_is_hs || (in_type == PID_TOKEN) || (in_type == PID_DATA);

    assign active   = (state_reg == ST_HDR) || (state_reg == ST_BODY) || (state_reg == ST_CRC);
    assign stuff    = active && (ones_cnt_reg == STUFF_LIMIT);
    assign cur_len  = phase_len(state_reg, is_data_reg);
    // CRC5 is left-aligned so both CRCs share one MSB-first index
    assign crc_tx   = is_data_reg ? ~crc16 : {~crc5, 11'd0};

    // Current unstuffed wire bit, taken from registered state only
    always_comb begin
        data_bit = 1'b0;
        case (state_reg)
            ST_HDR, ST_BODY: data_bit = shreg_reg[SHREG_W-1];
            ST_CRC:          data_bit = crc_tx[4'd15 - bit_cnt_reg[3:0]];
            default:         data_bit = 1'b0;
        endcase
    end

    assign tx_bit     = data_bit & ~stuff;
    assign ones_after = tx_bit ? ones_cnt_reg + 3'd1 : 3'd0;
    assign last_bit   = active && !stuff && (bit_cnt_reg == cur_len - 7'd1);
    // Past the final bit, waiting only for a trailing stuffed zero
    assign in_tail    = (bit_cnt_reg == cur_len);

    crc_serial #(.WIDTH(5), .POLY(CRC5_POLY), .INIT(CRC5_INIT)) u_crc5 (
        .clk (clk),
        .rst (rst),
        .init(accept),
        .en  ((state_reg == ST_BODY) && !stuff),
        .din (shreg_reg[SHREG_W-1]),
        .crc (crc5)
    );

    crc_serial #(.WIDTH(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u_crc16 (
        .clk (clk),
        .rst (rst),
        .init(accept),
        .en  ((state_reg == ST_BODY) && !stuff),
        .din (shreg_reg[SHREG_W-1]),
        .crc (crc16)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: phases advance on their last real bit; a pending stuff
    // after the final bit keeps the phase alive for one more cycle
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = in_good ? ST_HDR : ST_BAD;
                end
            end
            ST_HDR: begin
                if (stuff) begin
                    if (in_tail) state_next = ST_EOP1;
                end else if (last_bit) begin
                    if (!is_hs_reg)                      state_next = ST_BODY;
                    else if (ones_after != STUFF_LIMIT)  state_next = ST_EOP1;
                end
            end
            ST_BODY: begin
                if (last_bit) state_next = ST_CRC;
            end
            ST_CRC: begin
                if (stuff) begin
                    if (in_tail) state_next = ST_EOP1;
                end else if (last_bit && (ones_after != STUFF_LIMIT)) begin
                    state_next = ST_EOP1;
                end
            end
            ST_EOP1: state_next = ST_EOP2;
            ST_EOP2: state_next = ST_IDLE;
            ST_BAD:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state
    always_comb begin
        bus.readyEC = (state_reg == ST_IDLE);
        bus.sOut    = tx_bit;
        bus.sValid  = active;
        bus.sEop    = (state_reg == ST_EOP1) || (state_reg == ST_EOP2);
        bus.badPkt  = (state_reg == ST_BAD);
    end

    // Datapath: capture on accept, shift and count real bits, hold on stuffs
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_reg    <= '0;
            bit_cnt_reg  <= '0;
            ones_cnt_reg <= '0;
            is_hs_reg    <= 1'b0;
            is_data_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        shreg_reg    <= in_is_hs ? {bus.pktIn[HS_MSB:HS_LSB], 64'd0}
                                                 : {bus.pktIn[HDR_MSB:HDR_LSB], bus.pktIn[DAT_MSB:DAT_LSB]};
                        is_hs_reg    <= in_is_hs;
                        is_data_reg  <= !in_is_hs && (in_type == PID_DATA);
                        bit_cnt_reg  <= '0;
                        ones_cnt_reg <= '0;
                    end
                end
                ST_HDR, ST_BODY, ST_CRC: begin
                    if (stuff) begin
                        ones_cnt_reg <= '0;
                    end else begin
                        ones_cnt_reg <= ones_after;
                        bit_cnt_reg  <= (state_next != state_reg) ? 7'd0 : bit_cnt_reg + 7'd1;
                        if (state_reg != ST_CRC) begin
                            shreg_reg <= shreg_reg << 1;
                        end
                    end
                end
                default: begin
                    bit_cnt_reg  <= '0;
                    ones_cnt_reg <= '0;
                end
            endcase
        end
    end
endmodule
